hazard3_frontend: RTL and testbench



---
 rtl/hazard3_frontend.sv | 191 +++++++++++++++++++
 tb/tb_hazard3_frontend.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_frontend.sv
// Instruction fetch frontend: word-aligned AHB-Lite fetches into a small
// prefetch FIFO, feeding a two-halfword current instruction register (CIR).
module hazard3_frontend #(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          FIFO_DEPTH   = 2,
  parameter int          W_ADDR       = 32,
  parameter int          W_DATA       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [W_ADDR-1:0] i_haddr,
  output logic [1:0]        i_htrans,
  output logic [2:0]        i_hsize,
  input  logic              i_hready,
  input  logic [W_DATA-1:0] i_hrdata,
  input  logic              jump_target_vld,
  input  logic [W_ADDR-1:0] jump_target,
  output logic              f_jump_rdy,
  output logic              f_jump_now,
  output logic [31:0]       fd_cir,
  output logic [1:0]        fd_cir_vld,
  input  logic [1:0]        df_cir_use,
  input  logic              df_cir_lock
);

  localparam int W_LVL = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [W_ADDR-1:0] fetch_addr_q, fetch_addr_d;
  logic [1:0]        out_q, out_d;
  logic              skip_q, skip_d;
  logic [W_DATA-1:0] fifo_q [FIFO_DEPTH];
  logic [W_DATA-1:0] fifo_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] half_q, half_d;
  logic [W_LVL-1:0]  level_q, level_d;
  logic [31:0]       cir_q, cir_d;
  logic [1:0]        cir_vld_q, cir_vld_d;

  logic              jump_now, fetch_ok, accept, complete, push;
  logic              pop, take_half;
  logic [1:0]        remaining;
  logic [31:0]       shifted;
  logic [W_ADDR-1:0] jump_word;
  logic              unused_jt_lsb;

  assign unused_jt_lsb = jump_target[0];

  // Bus-side controls: a jump always wins the address phase; otherwise fetch
  // only while buffered plus in-flight words cannot exceed the FIFO.
  always_comb begin
    jump_now  = jump_target_vld && i_hready;
    jump_word = {jump_target[W_ADDR-1:2], 2'b00};
    fetch_ok  = (int'(level_q) + int'(out_q)) < FIFO_DEPTH;
    i_hsize   = 3'b010;
    i_haddr   = jump_now ? jump_word : fetch_addr_q;
    i_htrans  = HTRANS_IDLE;
    if (rst_n && (jump_now || fetch_ok))
      i_htrans = HTRANS_NONSEQ;
    f_jump_rdy = i_hready;
    f_jump_now = jump_now;
    accept     = i_htrans[1] && i_hready;
    complete   = i_hready && (out_q != 2'd0);
    // A data phase finishing alongside a jump belongs to the old stream.
    push       = complete && !jump_now;
  end

  // Fetch address, outstanding count and skip-half tracking.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (jump_now)
      fetch_addr_d = jump_word + W_ADDR'(4);
    else if (accept)
      fetch_addr_d = fetch_addr_q + W_ADDR'(4);
    out_d  = out_q + {1'b0, accept} - {1'b0, complete};
    skip_d = skip_q;
    if (jump_now)
      skip_d = jump_target[1];
    else if (push)
      skip_d = 1'b0;
  end

  // CIR shift and refill from the FIFO head word only.
  always_comb begin
    cir_d     = cir_q;
    cir_vld_d = cir_vld_q;
    pop       = 1'b0;
    take_half = 1'b0;
    remaining = cir_vld_q - df_cir_use;
    shifted   = cir_q;
    if (df_cir_use == 2'd1)
      shifted = {16'h0, cir_q[31:16]};
    else if (df_cir_use == 2'd2)
      shifted = 32'h0;
    if (jump_now && !df_cir_lock) begin
      cir_d     = 32'h0;
      cir_vld_d = 2'd0;
    end else if (!df_cir_lock) begin
      cir_d     = shifted;
      cir_vld_d = remaining;
      if (level_q != '0) begin
        if (remaining == 2'd0) begin
          pop = 1'b1;
          if (half_q[0]) begin
            cir_d[15:0] = fifo_q[0][31:16];
            cir_vld_d   = 2'd1;
          end else begin
            cir_d     = fifo_q[0];
            cir_vld_d = 2'd2;
          end
        end else if (remaining == 2'd1) begin
          cir_vld_d = 2'd2;
          if (half_q[0]) begin
            cir_d[31:16] = fifo_q[0][31:16];
            pop          = 1'b1;
          end else begin
            cir_d[31:16] = fifo_q[0][15:0];
            take_half    = 1'b1;
          end
        end
      end
    end
  end

  // Shifting prefetch FIFO: pop first, then push at the post-pop level.
  always_comb begin
    fifo_d  = fifo_q;
    half_d  = half_q;
    level_d = level_q;
    if (jump_now) begin
      level_d = '0;
      half_d  = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          fifo_d[i] = fifo_q[i+1];
          half_d[i] = half_q[i+1];
        end
        half_d[FIFO_DEPTH-1] = 1'b0;
        level_d = level_q - W_LVL'(1);
      end else if (take_half) begin
        half_d[0] = 1'b1;
      end
      if (push) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (level_d == W_LVL'(i)) begin
            fifo_d[i] = i_hrdata;
            half_d[i] = skip_q;
          end
        end
        level_d = level_d + W_LVL'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= {RESET_VECTOR[W_ADDR-1:2], 2'b00};
      out_q        <= 2'd0;
      skip_q       <= RESET_VECTOR[1];
      half_q       <= '0;
      level_q      <= '0;
      cir_q        <= 32'h0;
      cir_vld_q    <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      out_q        <= out_d;
      skip_q       <= skip_d;
      half_q       <= half_d;
      level_q      <= level_d;
      cir_q        <= cir_d;
      cir_vld_q    <= cir_vld_d;
      fifo_q       <= fifo_d;
    end
  end

  assign fd_cir     = cir_q;
  assign fd_cir_vld = cir_vld_q;

  // Illegal-usage checks: FIFO overflow and over-consumption by decode.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && level_q == W_LVL'(FIFO_DEPTH)));
      assert (df_cir_use <= cir_vld_q);
    end
  end

endmodule

// File: tb/tb_hazard3_frontend.sv
// Bench for hazard3_frontend: AHB memory model, decode consumer acting as a
// scoreboard monitor, and directed stimulus for reset, streaming, jumps,
// CIR lock and bus stalls.
module tb_hazard3_frontend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_haddr;
  logic [1:0]  i_htrans;
  logic [2:0]  i_hsize;
  logic        i_hready = 1'b1;
  logic [31:0] i_hrdata;
  logic        jump_target_vld = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        f_jump_rdy;
  logic        f_jump_now;
  logic [31:0] fd_cir;
  logic [1:0]  fd_cir_vld;
  logic [1:0]  df_cir_use = 2'd0;
  logic        df_cir_lock = 1'b0;

  always #5 clk = ~clk;

  hazard3_frontend #(
    .RESET_VECTOR(32'h100),
    .FIFO_DEPTH  (2),
    .W_ADDR      (32),
    .W_DATA      (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_haddr        (i_haddr),
    .i_htrans       (i_htrans),
    .i_hsize        (i_hsize),
    .i_hready       (i_hready),
    .i_hrdata       (i_hrdata),
    .jump_target_vld(jump_target_vld),
    .jump_target    (jump_target),
    .f_jump_rdy     (f_jump_rdy),
    .f_jump_now     (f_jump_now),
    .fd_cir         (fd_cir),
    .fd_cir_vld     (fd_cir_vld),
    .df_cir_use     (df_cir_use),
    .df_cir_lock    (df_cir_lock)
  );

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  int accepts = 0;
  logic [15:0] exp_q [$];
  bit [31:0] ovr [bit [31:0]];
  logic        dphase_q;
  logic [31:0] rdata_q;

  // Default memory content: each halfword holds its own byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    if (ovr.exists(a)) return ovr[a];
    lo = a[15:0];
    return {lo + 16'd2, lo};
  endfunction

  // AHB-Lite slave: data is looked up at address acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dphase_q <= 1'b0;
      rdata_q  <= 32'hDEAD_BEEF;
    end else if (i_hready) begin
      dphase_q <= (i_htrans == 2'b10);
      rdata_q  <= mem_word(i_haddr);
      if (i_htrans == 2'b10) accepts <= accepts + 1;
    end
  end
  assign i_hrdata = rdata_q;

  // Decode consumer and scoreboard monitor: every consumed halfword is
  // compared against the head of the expected queue.
  always @(negedge clk) begin : monitor
    int n;
    logic [15:0] hw, e;
    n = 0;
    if (rst_n && !df_cir_lock)
      n = (mode < int'(fd_cir_vld)) ? mode : int'(fd_cir_vld);
    for (int i = 0; i < n; i++) begin
      hw = fd_cir[i*16 +: 16];
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL cir_hw: got %h, expected queue empty", hw);
      end else begin
        e = exp_q.pop_front();
        if (hw !== e) begin
          fails++;
          $display("FAIL cir_hw: got %h, expected %h", hw, e);
        end
      end
    end
    df_cir_use = 2'(n);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(2 * i);
      exp_q.push_back(a[15:0]);
    end
  endtask

  task automatic do_jump(input logic [31:0] tgt);
    logic [31:0] w;
    w = {tgt[31:2], 2'b00};
    jump_target     = tgt;
    jump_target_vld = 1'b1;
    #1;
    check("jump_haddr", i_haddr, w);
    check("jump_htrans", 32'(i_htrans), 32'h2);
    check("jump_now", 32'(f_jump_now), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] snap_addr;
    logic [1:0]  snap_trans;
    ovr[32'h100] = 32'h0050_0093;
    ovr[32'h104] = 32'hAAAA_BBBB;
    ovr[32'h108] = 32'hCCCC_DDDD;
    ovr[32'h300] = 32'h0080_006F;

    repeat (3) @(negedge clk);
    #1;
    check("rst_htrans", 32'(i_htrans), 32'h0);
    check("rst_haddr", i_haddr, 32'h100);
    check("rst_cir_vld", 32'(fd_cir_vld), 32'h0);
    check("rst_cir", fd_cir, 32'h0);
    check("rst_hsize", 32'(i_hsize), 32'h2);
    #1 rst_n = 1'b1;
    #1;
    check("c1_htrans", 32'(i_htrans), 32'h2);
    check("c1_haddr", i_haddr, 32'h100);
    tick();
    check("c2_htrans", 32'(i_htrans), 32'h2);
    check("c2_haddr", i_haddr, 32'h104);
    tick();
    check("c3_cir_vld", 32'(fd_cir_vld), 32'h0);
    check("c3_htrans", 32'(i_htrans), 32'h0);
    tick();
    check("c4_cir_vld", 32'(fd_cir_vld), 32'h2);
    check("c4_cir", fd_cir, 32'h0050_0093);
    check("c4_haddr", i_haddr, 32'h108);

    // Decode stalled: two words buffered, CIR full, bus idle.
    repeat (4) tick();
    check("full_htrans", 32'(i_htrans), 32'h0);
    check("full_accepts", 32'(accepts), 32'd3);
    check("full_cir_vld", 32'(fd_cir_vld), 32'h2);

    exp_q.push_back(16'h0093);
    exp_q.push_back(16'h0050);
    exp_q.push_back(16'hBBBB);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'hDDDD);
    exp_q.push_back(16'hCCCC);
    push_stream(32'h10C, 40);
    mode = 2;
    repeat (3) tick();
    mode = 1;
    repeat (10) tick();

    // Jump to a halfword-aligned target while a data phase is in flight.
    k = 0;
    while (!dphase_q && k < 20) begin tick(); k++; end
    check("jump_dphase_seen", 32'(dphase_q), 32'h1);
    do_jump(32'h202);
    exp_q.delete();
    push_stream(32'h202, 40);
    tick();
    jump_target_vld = 1'b0;
    repeat (12) tick();

    // Fill CIR with a known word, then jump under lock.
    mode = 0;
    do_jump(32'h300);
    exp_q.delete();
    exp_q.push_back(16'h006F);
    exp_q.push_back(16'h0080);
    tick();
    jump_target_vld = 1'b0;
    k = 0;
    while (fd_cir_vld != 2'd2 && k < 10) begin tick(); k++; end
    check("lock_pre_cir", fd_cir, 32'h0080_006F);
    df_cir_lock = 1'b1;
    do_jump(32'h400);
    push_stream(32'h400, 40);
    tick();
    jump_target_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("lock_cir", fd_cir, 32'h0080_006F);
      check("lock_cir_vld", 32'(fd_cir_vld), 32'h2);
      tick();
    end
    df_cir_lock = 1'b0;
    mode = 2;
    repeat (4) tick();
    mode = 1;
    repeat (8) tick();

    // Jump request held off by a three-cycle bus stall.
    k = 0;
    while (i_htrans != 2'b10 && k < 20) begin tick(); k++; end
    check("stall_pre_nonseq", 32'(i_htrans), 32'h2);
    i_hready        = 1'b0;
    jump_target     = 32'h500;
    jump_target_vld = 1'b1;
    #1;
    snap_addr  = i_haddr;
    snap_trans = i_htrans;
    for (int i = 0; i < 3; i++) begin
      check("stall_jump_rdy", 32'(f_jump_rdy), 32'h0);
      check("stall_jump_now", 32'(f_jump_now), 32'h0);
      check("stall_haddr", i_haddr, snap_addr);
      check("stall_htrans", 32'(i_htrans), 32'(snap_trans));
      if (i < 2) tick();
    end
    tick();
    i_hready = 1'b1;
    do_jump(32'h500);
    exp_q.delete();
    push_stream(32'h500, 40);
    tick();
    jump_target_vld = 1'b0;
    repeat (12) tick();

    // Reset mid-transaction.
    rst_n = 1'b0;
    #1;
    check("mid_rst_htrans", 32'(i_htrans), 32'h0);
    check("mid_rst_cir_vld", 32'(fd_cir_vld), 32'h0);
    check("mid_rst_haddr", i_haddr, 32'h100);
    exp_q.delete();
    mode = 0;
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_htrans", 32'(i_htrans), 32'h2);
    check("post_rst_haddr", i_haddr, 32'h100);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
